// File: rtl/bcd_scan_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_scan_display_pkg
//  Purpose  : Shared seven-segment types and active-high patterns, bit order
//             {g,f,e,d,c,b,a}.
//  Revision : 1.0  initial release
// ============================================================================
package bcd_scan_display_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_0    = 7'h3F;
   localparam seg7_t SEG_1    = 7'h06;
   localparam seg7_t SEG_2    = 7'h5B;
   localparam seg7_t SEG_3    = 7'h4F;
   localparam seg7_t SEG_4    = 7'h66;
   localparam seg7_t SEG_5    = 7'h6D;
   localparam seg7_t SEG_6    = 7'h7D;
   localparam seg7_t SEG_7    = 7'h07;
   localparam seg7_t SEG_8    = 7'h7F;
   localparam seg7_t SEG_9    = 7'h6F;
   localparam seg7_t SEG_DASH = 7'h40;
   localparam seg7_t SEG_OFF  = 7'h00;

endpackage
`default_nettype wire

// File: rtl/bcd_scan_display_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_scan_display_if
//  Purpose  : Digit source to display-pin bundle. The master supplies BCD
//             digits and requests; the slave (the scanner) drives the pins.
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_scan_display_if
   import bcd_scan_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank_lz;
   seg7_t                   seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_start;

   modport master (
      output digits_in, dp_in, blank_lz,
      input  seg, dp, an, frame_start
   );

   modport slave (
      input  digits_in, dp_in, blank_lz,
      output seg, dp, an, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_display_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Purpose  : Combinational BCD to active-high seven-segment decoder.
//             Codes 10..15 are not valid BCD and show a dash.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
   import bcd_scan_display_pkg::*;
(
   input  logic [3:0] i_bcd,
   output seg7_t      o_seg
);

   // Map each BCD code to its segment pattern
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_scan_display
//  Purpose  : Time-multiplexed seven-segment scanner with per-frame digit
//             snapshot, leading-zero blanking and an all-off guard interval
//             at the start of every digit slot.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_scan_display
   import bcd_scan_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int GUARD      = 2,
   parameter int ACTIVE_LOW = 1
)(
   input  logic               clk,
   input  logic               reset,
   bcd_scan_display_if.slave  bus
);

   localparam int c_PW = $clog2(SCAN_DIV);
   localparam int c_IW = $clog2(NUM_DIGITS);

   localparam logic [c_PW-1:0] c_PLAST = c_PW'(SCAN_DIV - 1);
   localparam logic [c_PW-1:0] c_GUARD = c_PW'(GUARD);
   localparam logic [c_IW-1:0] c_ILAST = c_IW'(NUM_DIGITS - 1);
   localparam logic            c_INV   = (ACTIVE_LOW != 0);

   logic [c_PW-1:0]          r_pcnt;
   logic [c_IW-1:0]          r_idx;
   logic [4*NUM_DIGITS-1:0]  r_shadow_digits;
   logic [NUM_DIGITS-1:0]    r_shadow_dp;
   logic                     r_shadow_blz;
   logic                     r_primed;
   logic                     r_frame_start;
   seg7_t                    r_seg;
   logic                     r_dp;
   logic [NUM_DIGITS-1:0]    r_an;

   logic                     w_tick;
   logic                     w_snap;
   logic [NUM_DIGITS-1:0]    w_lead;
   logic [NUM_DIGITS-1:0]    w_blank;
   logic [3:0]               w_cur_digit;
   logic                     w_cur_blank;
   logic                     w_cur_dp;
   logic                     w_guard;
   seg7_t                    w_dec_seg;
   seg7_t                    w_seg_hi;
   logic                     w_dp_hi;
   logic [NUM_DIGITS-1:0]    w_an_hi;

   assign w_tick = (r_pcnt == c_PLAST);
   // A fresh snapshot is taken right after reset release and at the end of
   // the last slot, so a whole frame always shows one consistent value.
   assign w_snap = !r_primed || (w_tick && (r_idx == c_ILAST));

   // Prescaler, slot index and per-frame snapshot of the digit inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pcnt          <= '0;
         r_idx           <= '0;
         r_shadow_digits <= '0;
         r_shadow_dp     <= '0;
         r_shadow_blz    <= 1'b0;
         r_primed        <= 1'b0;
         r_frame_start   <= 1'b0;
      end else begin
         r_primed      <= 1'b1;
         r_frame_start <= w_snap;
         if (w_tick) begin
            r_pcnt <= '0;
            r_idx  <= (r_idx == c_ILAST) ? '0 : r_idx + c_IW'(1);
         end else begin
            r_pcnt <= r_pcnt + c_PW'(1);
         end
         if (w_snap) begin
            r_shadow_digits <= bus.digits_in;
            r_shadow_dp     <= bus.dp_in;
            r_shadow_blz    <= bus.blank_lz;
         end
      end
   end

   // w_lead[k]: digits k..top are all zero and none of them requests a dp
   always_comb begin
      w_lead = '0;
      w_lead[NUM_DIGITS-1] = (r_shadow_digits[4*(NUM_DIGITS-1) +: 4] == 4'd0)
                             && !r_shadow_dp[NUM_DIGITS-1];
      for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
         w_lead[k] = w_lead[k+1] && (r_shadow_digits[4*k +: 4] == 4'd0)
                     && !r_shadow_dp[k];
      end
   end

   // Digit 0 always stays visible so a zero value still shows "0"
   assign w_blank = r_shadow_blz ? {w_lead[NUM_DIGITS-1:1], 1'b0} : '0;

   assign w_cur_digit = r_shadow_digits[{r_idx, 2'b00} +: 4];
   assign w_cur_blank = w_blank[r_idx];
   assign w_cur_dp    = r_shadow_dp[r_idx];
   assign w_guard     = (r_pcnt < c_GUARD);

   bcd_to_seg7 u_dec (
      .i_bcd (w_cur_digit),
      .o_seg (w_dec_seg)
   );

   assign w_seg_hi = (w_guard || w_cur_blank) ? SEG_OFF : w_dec_seg;
   assign w_dp_hi  = !w_guard && !w_cur_blank && w_cur_dp;
   assign w_an_hi  = w_guard ? '0 : (NUM_DIGITS'(1) << r_idx);

   // Output registers; polarity is applied only here
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg <= {7{c_INV}};
         r_dp  <= c_INV;
         r_an  <= {NUM_DIGITS{c_INV}};
      end else begin
         r_seg <= w_seg_hi ^ {7{c_INV}};
         r_dp  <= w_dp_hi ^ c_INV;
         r_an  <= w_an_hi ^ {NUM_DIGITS{c_INV}};
      end
   end

   assign bus.seg         = r_seg;
   assign bus.dp          = r_dp;
   assign bus.an          = r_an;
   assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_scan_display
//  Purpose  : Scoreboard bench for the seven-segment scanner.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_scan_display;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int GD = 1;
   localparam int AL = 1;
   localparam int FRAME = ND * SD;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } slot_t;

   localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic rst_q = 1'b1;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   to_snap;

   slot_t exp_q[$];
   int    fs_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   bcd_scan_display_if #(.NUM_DIGITS(ND)) bus ();

   bcd_scan_display #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD),
      .GUARD      (GD),
      .ACTIVE_LOW (AL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: an=%b seg=%h dp=%b fs=%b (cycle %0d)",
               name, bus.an, bus.seg, bus.dp, bus.frame_start, cyc);
   endtask

   // Reference: what digit k of a frame captured from (d,p,b) looks like on the pins
   function automatic slot_t model_slot(input int k, input logic [15:0] d,
                                        input logic [3:0] p, input logic b);
      slot_t      s;
      int         v;
      bit         blank;
      logic [6:0] pat;
      v     = int'((d >> (4 * k)) & 16'hF);
      blank = b && (k != 0) && ((d >> (4 * k)) == 16'd0) && ((p >> k) == 4'd0);
      pat   = blank ? 7'h00 : ((v < 10) ? PAT[v] : 7'h40);
      s.an  = ~(4'b0001 << k);
      s.seg = ~pat;
      s.dp  = ~(!blank && p[k]);
      return s;
   endfunction

   task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic b);
      for (int k = 0; k < ND; k++) exp_q.push_back(model_slot(k, d, p, b));
      fs_q.push_back(cyc);
   endtask

   // Monitor: compares every lit cycle against the scoreboard head
   initial begin
      int         run;
      logic [3:0] prev_an;
      run     = 0;
      prev_an = 4'hF;
      forever begin
         @(negedge clk);
         if (rst_q) begin
            exp_q.delete();
            fs_q.delete();
            run     = 0;
            prev_an = 4'hF;
            chk("reset_state", {bus.an, bus.seg, bus.dp, bus.frame_start},
                {4'hF, 7'h7F, 1'b1, 1'b0});
         end else begin
            if (bus.frame_start) begin
               if (fs_q.size() == 0) flag("frame_start_unexpected");
               else chk("frame_start_cycle", fs_q.pop_front(), cyc);
            end else if (fs_q.size() > 0 && fs_q[0] <= cyc) begin
               flag("frame_start_missing");
               void'(fs_q.pop_front());
            end
            if (bus.an == 4'hF) begin
               chk("idle_off", {bus.seg, bus.dp}, {7'h7F, 1'b1});
               if (run != 0) flag("lit_too_short");
               run = 0;
            end else begin
               if (prev_an != 4'hF && prev_an != bus.an) flag("no_guard");
               if (exp_q.size() == 0) begin
                  flag("unexpected_lit");
               end else begin
                  chk("slot", {bus.an, bus.seg, bus.dp}, exp_q[0]);
                  run++;
                  if (run == SD - GD) begin
                     void'(exp_q.pop_front());
                     run = 0;
                  end
               end
            end
            prev_an = bus.an;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic b);
      bus.digits_in = d;
      bus.dp_in     = p;
      bus.blank_lz  = b;
   endtask

   task automatic rand_in();
      set_in(16'($urandom), 4'($urandom), 1'($urandom));
   endtask

   task automatic release_with(input logic [15:0] d, input logic [3:0] p, input logic b);
      set_in(d, p, b);
      reset = 1'b0;
      step();
      push_frame(d, p, b);
      to_snap = FRAME - 1;
   endtask

   // Drive one frame period ending in a snapshot of (d,p,b).
   // mode 0: hold, 1: random noise mid-frame, 2: switch to (d,p,b) mid-frame.
   task automatic run_frame(input logic [15:0] d, input logic [3:0] p, input logic b,
                            input int mode, input int rst_at);
      for (int i = 1; i <= to_snap; i++) begin
         if (rst_at == i) begin
            reset = 1'b1;
            rand_in();
            repeat ($urandom_range(1, 3)) step();
            release_with(d, p, b);
            return;
         end
         if (i == to_snap) set_in(d, p, b);
         else if (mode == 1) rand_in();
         else if (mode == 2 && i == to_snap / 2) set_in(d, p, b);
         step();
      end
      push_frame(d, p, b);
      to_snap = FRAME;
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] d;
      logic [15:0] mask;
      int          nz;
      d    = 16'($urandom);
      nz   = $urandom_range(0, 4);
      mask = 16'hFFFF >> (4 * nz);
      return d & mask;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(16'h0000, 4'h0, 1'b0);
      reset = 1'b1;
      repeat (3) step();
      release_with(16'h1234, 4'h0, 1'b0);
      run_frame(16'h0007, 4'h0, 1'b1, 0, 0);
      run_frame(16'h0007, 4'h0, 1'b0, 0, 0);
      run_frame(16'h0050, 4'b0100, 1'b1, 1, 0);
      run_frame(16'h00A9, 4'h0, 1'b0, 0, 0);
      run_frame(16'h0009, 4'h0, 1'b0, 0, 0);
      run_frame(16'h0010, 4'h0, 1'b0, 2, 0);
      run_frame(16'h0000, 4'h0, 1'b1, 0, 0);
      run_frame(16'h4321, 4'h1, 1'b1, 0, 6);
      for (int f = 0; f < 30; f++) begin
         logic [15:0] d;
         logic [3:0]  p;
         int          ra;
         d  = rand_digits();
         p  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         ra = ($urandom_range(0, 5) == 0) ? $urandom_range(1, to_snap - 1) : 0;
         run_frame(d, p, 1'($urandom), $urandom_range(0, 2), ra);
      end
      run_frame(16'h9876, 4'h0, 1'b0, 0, 0);
      run_frame(16'h0001, 4'h0, 1'b1, 0, 0);
      @(negedge clk);
      #1;
      chk("drain_pending", exp_q.size(), ND);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_scan_display.md
# bcd_scan_display

Multiplexed seven-segment driver that consumes the parallel BCD digits produced by the cascaded decade-counter chain. It time-multiplexes up to NUM_DIGITS digits onto one shared segment bus with per-digit anode enables, leading-zero blanking and anti-ghosting guard time. Digit values are snapshotted once per scan frame so a counter carry ripple never tears a displayed frame.

## Interface
- NUM_DIGITS, 4, digits driven (2..8); digit 0 = least significant
- SCAN_DIV, 50000, clk cycles per digit slot (>= GUARD+2)
- GUARD, 2, cycles at start of each slot with all anodes inactive
- ACTIVE_LOW, 1, 1 = seg/dp/an pins active-low; 0 = active-high

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- digits_in  in  4*NUM_DIGITS  BCD digits; digit k at [4k+3:4k]
- dp_in  in  NUM_DIGITS  decimal point request per digit
- blank_lz  in  1  1 = enable leading-zero blanking
- seg  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point segment
- an  out  NUM_DIGITS  one-hot digit enable
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1; tick = (pcnt == SCAN_DIV-1); pcnt wraps to 0 on tick.
- Slot index idx advances on tick, 0..NUM_DIGITS-1, wraps to 0.
- Snapshot: shadow_digits/shadow_dp/shadow_blz <= digits_in/dp_in/blank_lz when (tick && idx == NUM_DIGITS-1) or on the first cycle after reset release (primed flag). frame_start = 1 in that same cycle's next-state, i.e. registered, high for exactly one cycle per snapshot.
- Decode per digit: 0-9 standard patterns; 10-15 show dash (g only); dp from shadow_dp.
- Leading-zero blanking (shadow_blz = 1): digit k blanked iff all digits k..NUM_DIGITS-1 equal 0 and k != 0. Digit 0 never blanked. A digit with its dp set is never blanked, nor are digits below it.
- Blanked digit: seg and dp inactive; its anode still follows the scan.
- Guard: while pcnt < GUARD, all an inactive, seg/dp inactive. Otherwise an[idx] active, seg/dp = decoded shadow digit idx.
- ACTIVE_LOW inverts seg, dp, an at the output registers only.

## Timing
- All outputs registered; one-cycle latency from pcnt/idx/shadow to pins.
- Reset values: pcnt 0, idx 0, shadow 0, primed 0, frame_start 0, an/seg/dp all inactive (all 1s when ACTIVE_LOW).
- Frame length NUM_DIGITS*SCAN_DIV cycles; each digit lit SCAN_DIV-GUARD cycles per frame.
- Changes on digits_in mid-frame have no effect until next snapshot.
- Reset mid-frame: outputs inactive next cycle; after release, snapshot taken immediately, scan restarts at idx 0 with guard.
- At most one an active in any cycle; an never changes from one active digit directly to another without >= GUARD inactive cycles.

## Structure
- Shared package: segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF, active-high, {g..a} order).
- Sub-module bcd_to_seg7: combinational 4-bit BCD -> 7-bit pattern, dash for 10-15.
- Top holds prescaler, scan index, snapshot, blanking logic, output registers.

## Test plan
(NUM_DIGITS=4, SCAN_DIV=4, GUARD=1, ACTIVE_LOW=1)
- Reset held 3 cycles -> seg=7'h7F, dp=1, an=4'hF, frame_start=0 throughout.
- digits_in=16'h1234, blank_lz=0 after release -> frame_start pulse, then slots show an=1110 seg for 4, 1101 for 3, 1011 for 2, 0111 for 1, each lit 3 cycles after 1 all-off guard cycle.
- digits_in=16'h0007, blank_lz=1 -> only an[0] lights with "7"; digits 1-3 seg=7'h7F; with blank_lz=0 they show "0".
- digits_in=16'h0050, dp_in=4'b0100, blank_lz=1 -> digit 3 blanked; digit 2 shows "0" with dp=0; digits 1,0 show 5,0.
- digits_in=16'h00A9 -> digit 1 shows dash (seg=7'h3F), digit 0 shows 9.
- Change digits_in from 16'h0009 to 16'h0010 mid-frame -> display stays 0009 until next frame_start, then 0010; reset asserted mid-slot -> outputs inactive next cycle, scan restarts at idx 0.
